// File: rtl/rename_regfile_mp_pkg.sv
// Shared definitions for the multi-port rename register file.
// Holds default widths, the ROB tag type and common constants.
package rename_regfile_mp_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_ROB_W = 4;

  localparam logic [DEF_XLEN-1:0] ZERO_WORD = 32'h0000_0000;

  typedef logic [DEF_ROB_W-1:0] rob_tag_t;
  localparam rob_tag_t ZERO_ROB = 4'h0;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

// File: rtl/rename_regfile_mp_read_port.sv
// rf_read_port: one operand read port of the rename register file.
// Looks up value/tag/busy for idx and overrides value/busy when a valid
// commit in this same cycle retires the current producer of idx.
// Ports:
//   idx                      register index to read
//   value_flat/tag_flat/busy_flat  current register state, flattened
//   cm_valid/cm_reg/cm_rob/cm_value commit ports (higher index = younger)
//   value/tag/busy           operand outputs (combinational)
module rf_read_port
  import rename_regfile_mp_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREG  = 32,
  parameter int REG_W = $clog2(NREG),
  parameter int ROB_W = DEF_ROB_W,
  parameter int NCM   = 1
) (
  input  logic [REG_W-1:0]      idx,
  input  logic [NREG*XLEN-1:0]  value_flat,
  input  logic [NREG*ROB_W-1:0] tag_flat,
  input  logic [NREG-1:0]       busy_flat,
  input  logic [NCM-1:0]        cm_valid,
  input  logic [NCM*REG_W-1:0]  cm_reg,
  input  logic [NCM*ROB_W-1:0]  cm_rob,
  input  logic [NCM*XLEN-1:0]   cm_value,
  output logic [XLEN-1:0]       value,
  output logic [ROB_W-1:0]      tag,
  output logic                  busy
);

  logic [XLEN-1:0]  value_s;
  logic [ROB_W-1:0] tag_s;
  logic             busy_s;

  // Lookup plus commit bypass; later (younger) ports overwrite earlier ones.
  always_comb begin
    value_s = value_flat[idx*XLEN +: XLEN];
    tag_s   = tag_flat[idx*ROB_W +: ROB_W];
    busy_s  = busy_flat[idx];
    for (int i = 0; i < NCM; i++) begin
      if (busy_flat[idx] && cm_valid[i] &&
          (cm_reg[i*REG_W +: REG_W] == idx) &&
          (cm_rob[i*ROB_W +: ROB_W] == tag_flat[idx*ROB_W +: ROB_W])) begin
        value_s = cm_value[i*XLEN +: XLEN];
        busy_s  = FALSE;
      end else begin
        busy_s  = busy_s;
      end
    end
  end

  assign value = value_s;
  assign tag   = tag_s;
  assign busy  = busy_s;

endmodule

// File: rtl/rename_regfile_mp.sv
// rename_regfile_mp: architectural register file plus rename table with
// NRD read ports and NCM in-order commit ports.
// Ports:
//   clk, rst (sync, active-high), rdy (global enable)
//   rd_idx / rd_value / rd_rob / rd_busy   operand read ports
//   disp_valid / disp_reg / disp_rob       destination claim from dispatch
//   cm_valid / cm_reg / cm_rob / cm_value  commit ports (higher = younger)
//   flush                                   clears all busy bits and tags
module rename_regfile_mp
  import rename_regfile_mp_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREG  = 32,
  parameter int REG_W = $clog2(NREG),
  parameter int ROB_W = DEF_ROB_W,
  parameter int NRD   = 2,
  parameter int NCM   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [NRD*REG_W-1:0]  rd_idx,
  output logic [NRD*XLEN-1:0]   rd_value,
  output logic [NRD*ROB_W-1:0]  rd_rob,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  disp_valid,
  input  logic [REG_W-1:0]      disp_reg,
  input  logic [ROB_W-1:0]      disp_rob,
  input  logic [NCM-1:0]        cm_valid,
  input  logic [NCM*REG_W-1:0]  cm_reg,
  input  logic [NCM*ROB_W-1:0]  cm_rob,
  input  logic [NCM*XLEN-1:0]   cm_value,
  input  logic                  flush
);

  logic [NREG*XLEN-1:0]  value_flat_s;
  logic [NREG*ROB_W-1:0] tag_flat_s;
  logic [NREG-1:0]       busy_flat_s;

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    if (r == 0) begin : g_zero
      // x0 has no storage: always zero, never busy.
      assign value_flat_s[0 +: XLEN]  = {XLEN{FALSE}};
      assign tag_flat_s[0 +: ROB_W]   = {ROB_W{FALSE}};
      assign busy_flat_s[0]           = FALSE;
    end else begin : g_live
      logic [XLEN-1:0]  value_d, value_q;
      logic [ROB_W-1:0] tag_d, tag_q;
      logic             busy_d, busy_q;
      logic             cm_hit_s, cm_match_s;
      logic [XLEN-1:0]  cm_val_s;

      // Gather commits to this register: youngest value, any tag match.
      always_comb begin
        cm_hit_s   = FALSE;
        cm_match_s = FALSE;
        cm_val_s   = value_q;
        for (int i = 0; i < NCM; i++) begin
          if (cm_valid[i] && (cm_reg[i*REG_W +: REG_W] == REG_W'(r))) begin
            cm_hit_s = TRUE;
            cm_val_s = cm_value[i*XLEN +: XLEN];
            if (cm_rob[i*ROB_W +: ROB_W] == tag_q) begin
              cm_match_s = TRUE;
            end else begin
              cm_match_s = cm_match_s;
            end
          end else begin
            cm_hit_s = cm_hit_s;
          end
        end
      end

      // Next state with priority rst > flush > dispatch > commit.
      always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        busy_d  = busy_q;
        if (rst) begin
          value_d = {XLEN{FALSE}};
          tag_d   = {ROB_W{FALSE}};
          busy_d  = FALSE;
        end else if (rdy) begin
          // Commit values land even under flush; only busy/tag are cleared.
          if (cm_hit_s) begin
            value_d = cm_val_s;
          end else begin
            value_d = value_q;
          end
          if (flush) begin
            tag_d  = {ROB_W{FALSE}};
            busy_d = FALSE;
          end else if (disp_valid && (disp_reg == REG_W'(r))) begin
            tag_d  = disp_rob;
            busy_d = TRUE;
          end else if (cm_match_s) begin
            busy_d = FALSE;
          end else begin
            busy_d = busy_q;
          end
        end else begin
          busy_d = busy_q;
        end
      end

      // Per-register state flops.
      always_ff @(posedge clk) begin
        value_q <= value_d;
        tag_q   <= tag_d;
        busy_q  <= busy_d;
      end

      assign value_flat_s[r*XLEN +: XLEN]  = value_q;
      assign tag_flat_s[r*ROB_W +: ROB_W]  = tag_q;
      assign busy_flat_s[r]                = busy_q;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    rf_read_port #(
      .XLEN(XLEN), .NREG(NREG), .REG_W(REG_W), .ROB_W(ROB_W), .NCM(NCM)
    ) u_rd (
      .idx        (rd_idx[p*REG_W +: REG_W]),
      .value_flat (value_flat_s),
      .tag_flat   (tag_flat_s),
      .busy_flat  (busy_flat_s),
      .cm_valid   (cm_valid),
      .cm_reg     (cm_reg),
      .cm_rob     (cm_rob),
      .cm_value   (cm_value),
      .value      (rd_value[p*XLEN +: XLEN]),
      .tag        (rd_rob[p*ROB_W +: ROB_W]),
      .busy       (rd_busy[p])
    );
  end

endmodule

// File: tb/tb_rename_regfile_mp.sv
// Scoreboard bench for rename_regfile_mp (NRD=2, NCM=2).
module tb_rename_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int REG_W = 5;
  localparam int ROB_W = 4;
  localparam int NRD   = 2;
  localparam int NCM   = 2;

  logic                 clk = 1'b0;
  logic                 rst, rdy, disp_valid, flush;
  logic [NRD*REG_W-1:0] rd_idx;
  logic [NRD*XLEN-1:0]  rd_value;
  logic [NRD*ROB_W-1:0] rd_rob;
  logic [NRD-1:0]       rd_busy;
  logic [REG_W-1:0]     disp_reg;
  logic [ROB_W-1:0]     disp_rob;
  logic [NCM-1:0]       cm_valid;
  logic [NCM*REG_W-1:0] cm_reg;
  logic [NCM*ROB_W-1:0] cm_rob;
  logic [NCM*XLEN-1:0]  cm_value;

  typedef struct {
    string       nm;
    int          port;
    logic [31:0] val;
    logic [3:0]  tag;
    logic        busy;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad   = 0;

  rename_regfile_mp #(
    .XLEN(XLEN), .NREG(NREG), .REG_W(REG_W), .ROB_W(ROB_W), .NRD(NRD), .NCM(NCM)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rd_idx(rd_idx), .rd_value(rd_value), .rd_rob(rd_rob), .rd_busy(rd_busy),
    .disp_valid(disp_valid), .disp_reg(disp_reg), .disp_rob(disp_rob),
    .cm_valid(cm_valid), .cm_reg(cm_reg), .cm_rob(cm_rob), .cm_value(cm_value),
    .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    disp_valid = 1'b0; disp_reg = 5'd0; disp_rob = 4'd0;
    cm_valid = '0; cm_reg = '0; cm_rob = '0; cm_value = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic disp(input int r, input int rob);
    disp_valid = 1'b1;
    disp_reg   = r[4:0];
    disp_rob   = rob[3:0];
  endtask

  task automatic cm(input int port, input int r, input int rob, input logic [31:0] v);
    cm_valid[port]               = 1'b1;
    cm_reg[port*REG_W +: REG_W]  = r[4:0];
    cm_rob[port*ROB_W +: ROB_W]  = rob[3:0];
    cm_value[port*XLEN +: XLEN]  = v;
  endtask

  // Select read index and queue the expected result for the monitor.
  task automatic rd(input int p, input int r, input logic [31:0] v,
                    input logic [3:0] t, input logic b, input string nm);
    exp_t e;
    rd_idx[p*REG_W +: REG_W] = r[4:0];
    e.nm = nm; e.port = p; e.val = v; e.tag = t; e.busy = b;
    sb_q.push_back(e);
  endtask

  // Monitor: compare every queued expectation mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        exp_t e;
        logic [31:0] gv;
        logic [3:0]  gt;
        logic        gb;
        e  = sb_q.pop_front();
        gv = rd_value[e.port*XLEN +: XLEN];
        gt = rd_rob[e.port*ROB_W +: ROB_W];
        gb = rd_busy[e.port];
        total++;
        if ({gv, gt, gb} !== {e.val, e.tag, e.busy}) begin
          bad++;
          $display("FAIL %s port%0d: got val=%h tag=%0d busy=%b want val=%h tag=%0d busy=%b",
                   e.nm, e.port, gv, gt, gb, e.val, e.tag, e.busy);
        end
      end
    end
  end

  initial begin
    idle();
    rd_idx = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    idle();

    for (int r = 1; r < NREG; r++) begin
      rd(0, r, 32'h0, 4'd0, 1'b0, "reset_p0");
      rd(1, NREG - r, 32'h0, 4'd0, 1'b0, "reset_p1");
      tick();
    end

    disp(0, 3); rd(0, 0, 32'h0, 4'd0, 1'b0, "x0_disp_same"); tick();
    rd(0, 0, 32'h0, 4'd0, 1'b0, "x0_disp_after"); tick();

    disp(5, 7); rd(0, 5, 32'h0, 4'd0, 1'b0, "x5_no_disp_bypass"); tick();
    rd(0, 5, 32'h0, 4'd7, 1'b1, "x5_busy"); tick();
    cm(0, 5, 7, 32'hDEADBEEF);
    rd(0, 5, 32'hDEADBEEF, 4'd7, 1'b0, "x5_bypass_p0");
    rd(1, 5, 32'hDEADBEEF, 4'd7, 1'b0, "x5_bypass_p1"); tick();
    rd(0, 5, 32'hDEADBEEF, 4'd7, 1'b0, "x5_stored"); tick();

    disp(5, 7); tick();
    disp(5, 9); tick();
    cm(0, 5, 7, 32'h11); rd(0, 5, 32'hDEADBEEF, 4'd9, 1'b1, "x5_stale_nobyp"); tick();
    rd(0, 5, 32'h11, 4'd9, 1'b1, "x5_stale_commit"); tick();

    disp(6, 2); tick();
    cm(0, 6, 2, 32'h22); disp(6, 4); rd(0, 6, 32'h22, 4'd2, 1'b0, "x6_bypass"); tick();
    rd(0, 6, 32'h22, 4'd4, 1'b1, "x6_cm_and_disp"); tick();

    disp(8, 2); tick();
    cm(0, 8, 1, 32'hA); cm(1, 8, 2, 32'hB); rd(0, 8, 32'hB, 4'd2, 1'b0, "x8_bypass"); tick();
    rd(0, 8, 32'hB, 4'd2, 1'b0, "x8_two_port"); tick();

    disp(9, 1); tick();
    cm(0, 9, 1, 32'hC); cm(1, 9, 3, 32'hD); rd(1, 9, 32'hC, 4'd1, 1'b0, "x9_bypass_match"); tick();
    rd(1, 9, 32'hD, 4'd1, 1'b0, "x9_youngest_value"); tick();

    cm(0, 0, 0, 32'hFF); disp(0, 5); tick();
    rd(0, 0, 32'h0, 4'd0, 1'b0, "x0_commit"); tick();

    disp(3, 1); tick();
    disp(4, 2); tick();
    flush = 1'b1; cm(0, 3, 9, 32'h33); disp(4, 5); tick();
    rd(0, 3, 32'h33, 4'd0, 1'b0, "flush_x3");
    rd(1, 4, 32'h0, 4'd0, 1'b0, "flush_x4"); tick();
    rd(0, 5, 32'h11, 4'd0, 1'b0, "flush_x5");
    rd(1, 8, 32'hB, 4'd0, 1'b0, "flush_x8"); tick();

    rdy = 1'b0; cm(0, 5, 0, 32'h55); disp(7, 6);
    rd(0, 5, 32'h11, 4'd0, 1'b0, "rdy0_comb"); tick();
    rd(0, 5, 32'h11, 4'd0, 1'b0, "rdy0_x5");
    rd(1, 7, 32'h0, 4'd0, 1'b0, "rdy0_x7"); tick();

    disp(6, 3); tick();
    rdy = 1'b0; rst = 1'b1; tick();
    rd(0, 5, 32'h0, 4'd0, 1'b0, "rst_over_rdy_x5");
    rd(1, 6, 32'h0, 4'd0, 1'b0, "rst_over_rdy_x6"); tick();

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got pending=%0d want pending=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rename_regfile_mp.md
Name: rename_regfile_mp

Overview:
- Parametrised architectural register file plus rename (register-status) table for the Tomasulo core.
- Generalises the single-commit, two-read regfile to N read ports and M commit ports, with same-cycle commit-to-read bypass.
- Sits between decoder/dispatch (reads operands, claims the destination tag) and ROB (in-order commit, mispredict flush).

Parameters:
- XLEN, 32, data width.
- NREG, 32, architectural register count; reg 0 is hardwired zero.
- REG_W, $clog2(NREG), register index width (derived).
- ROB_W, 4, ROB tag width.
- NRD, 2, number of operand read ports.
- NCM, 1, commit ports per cycle; port i+1 is younger than port i.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; state frozen when low
- rd_idx  in  NRD*REG_W  read register indices, port p at [p*REG_W +: REG_W]
- rd_value  out  NRD*XLEN  operand values
- rd_rob  out  NRD*ROB_W  producing ROB tag when busy
- rd_busy  out  NRD  operand not yet available
- disp_valid  in  1  dispatch claims a destination this cycle
- disp_reg  in  REG_W  destination register
- disp_rob  in  ROB_W  destination ROB tag
- cm_valid  in  NCM  commit valid per port
- cm_reg  in  NCM*REG_W  commit destination (0 means no write)
- cm_rob  in  NCM*ROB_W  committing ROB tag
- cm_value  in  NCM*XLEN  committed value
- flush  in  1  mispredict / ROB clear

Behaviour:
- State: value[NREG], tag[NREG], busy[NREG]; all updated on posedge clk. Read outputs are combinational.
- Reset (rst=1 at posedge): every value, tag and busy entry is 0. rst has priority over rdy.
- rdy=0: no state change; read outputs remain combinational from the current state.
- Reg 0: never written, never busy; reads return value 0, tag 0, busy 0 regardless of any commit or dispatch.
- Commit, port i valid with reg r≠0:
  - value[r] ← cm_value next cycle.
  - busy[r] cleared only if cm_rob == tag[r] (pre-update tag).
- Multiple commit ports targeting the same r in one cycle: the youngest (highest index) port's value wins. Busy clears if any matching port's tag equals tag[r].
- Dispatch (disp_valid, disp_reg≠0): busy ← 1, tag ← disp_rob.
- Dispatch and commit to the same reg in one cycle: value from the commit; busy=1 and tag=disp_rob from the dispatch.
- Flush:
  - All busy ← 0 and all tag ← 0.
  - Commits in the same cycle still write values.
  - Dispatch in the same cycle is ignored.
  - Flush overrides busy/tag updates from commit and dispatch.
- Read port p, index r, default outputs: value[r], tag[r], busy[r].
- Read bypass: if busy[r] and some valid commit port has cm_reg==r and cm_rob==tag[r], output rd_busy=0 and rd_value = the youngest such port's value.
- No dispatch bypass: reads return pre-dispatch state, so a source equal to its own destination (e.g. addi x5,x5,1) reads the old producer.
- Write latency: 1 cycle. Read latency: 0 cycles.
- Tag wrap-around: tag equality only, no age comparison. A stale commit whose tag no longer matches tag[r] writes the value but leaves busy set.

Decomposition:
- Shared definitions package: XLEN, ZERO_WORD, ROB tag type, ZERO_ROB, TRUE/FALSE.
- One sub-module, rf_read_port: a single port's lookup plus commit-bypass priority mux, instantiated NRD times via generate.
- Write logic stays in the top as a per-register generate loop with explicit priority: rst > flush > dispatch > commit.

Test Plan:
- Reset, then read x1..x31 -> value 0, tag 0, busy 0 on all ports. Dispatch x0 (rob 3) then read x0 -> busy 0, value 0.
- Dispatch x5 with rob 7; next cycle read x5 -> busy 1, tag 7. Commit x5/rob 7/value 0xDEADBEEF -> in the same cycle the read shows busy 0 and value 0xDEADBEEF (bypass); the next cycle the stored value is 0xDEADBEEF and busy 0.
- Dispatch x5 rob 7, then dispatch x5 rob 9, then commit x5 rob 7 value 0x11 -> value 0x11, busy remains 1, tag remains 9.
- In the same cycle, commit x6 rob 2 (value 0x22, tag matches) and dispatch x6 rob 4 -> next cycle value 0x22, busy 1, tag 4.
- NCM=2: both ports commit x8 (rob 1 value 0xA, rob 2 value 0xB) with tag[x8]=2 -> value 0xB, busy 0.
- With x3, x4 busy, assert flush together with commit x3 value 0x33 and dispatch x4 rob 5 -> all busy 0, tags 0, value[x3]=0x33. Hold rdy=0 with a commit -> no state change.
